wb_simple_master: RTL

Single-transfer Wishbone classic initiator that drives the p_wb_* bus toward slaves such as the video-in control register bank at 0xb0000000. Accepts one command at a time on a valid/ready command port, runs one classic Wishbone cycle, handles ACK/ERR/RTY, and returns a status plus read data on a valid/ready response port. Used by test firmware models and by on-chip controllers that program the video_in register slaves.

---
 rtl/wb_master_pkg.sv | 30 +++
 rtl/wb_master_watchdog.sv | 34 +++
 rtl/wb_simple_master.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// Shared types and bus widths for the Wishbone single-transfer master.
package wb_master_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    BACKOFF,
    RSP
  } state_e;

  typedef enum logic [1:0] {
    OK              = 2'b00,
    ERR             = 2'b01,
    RETRY_EXHAUSTED = 2'b10,
    TIMEOUT         = 2'b11
  } status_e;

  typedef struct packed {
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
    logic [WB_SEL_W-1:0] sel;
    logic                lock;
  } cmd_t;

endpackage

// File: rtl/wb_master_watchdog.sv
// Per-attempt bus watchdog: counts enabled cycles, flags the last one.
module wb_master_watchdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // High during the LIMIT-th enabled cycle, so the edge ending it expires.
  assign expired = en && (cnt_q == 8'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_simple_master.sv
// Single-transfer Wishbone classic initiator with RTY reissue.
// WB_MASTER_TIMEOUT_EN adds the per-attempt bus watchdog.
module wb_simple_master
  import wb_master_pkg::*;
#(
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                p_clk,
  input  logic                p_resetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [WB_ADR_W-1:0] cmd_adr,
  input  logic [WB_DAT_W-1:0] cmd_dat,
  input  logic [WB_SEL_W-1:0] cmd_sel,
  input  logic                cmd_lock,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [1:0]          rsp_status,
  output logic [WB_DAT_W-1:0] rsp_dat,
  output logic [WB_ADR_W-1:0] p_wb_ADR_O,
  output logic [WB_DAT_W-1:0] p_wb_DAT_O,
  input  logic [WB_DAT_W-1:0] p_wb_DAT_I,
  output logic [WB_SEL_W-1:0] p_wb_SEL_O,
  output logic                p_wb_WE_O,
  output logic                p_wb_CYC_O,
  output logic                p_wb_STB_O,
  output logic                p_wb_LOCK_O,
  input  logic                p_wb_ACK_I,
  input  logic                p_wb_ERR_I,
  input  logic                p_wb_RTY_I
);

  state_e              state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  status_e             status_q, status_d;
  logic [3:0]          retry_q, retry_d;
  logic [WB_DAT_W-1:0] rdat_q, rdat_d;
  logic                cyc_q, cyc_d;
  logic                lock_q, lock_d;
  logic                rdy_q, rdy_d;
  logic                vld_q, vld_d;
  logic                wd_expired;
  logic                done;
  status_e             done_st;

`ifdef WB_MASTER_TIMEOUT_EN
  wb_master_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wd (
    .clk    (p_clk),
    .rst_n  (p_resetn),
    .clr    (state_q != BUS),
    .en     (state_q == BUS),
    .expired(wd_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT_CYCLES);
  assign wd_expired     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    status_d = status_q;
    retry_d  = retry_q;
    rdat_d   = rdat_q;
    cyc_d    = cyc_q;
    lock_d   = lock_q;
    rdy_d    = rdy_q;
    vld_d    = vld_q;
    done     = 1'b0;
    done_st  = OK;
    unique case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (cmd_valid && rdy_q) begin
          cmd_d = '{we: cmd_we, adr: cmd_adr,
                    dat: cmd_dat, sel: cmd_sel,
                    lock: cmd_lock};
          retry_d = '0;
          rdy_d   = 1'b0;
          cyc_d   = 1'b1;
          lock_d  = cmd_lock;
          state_d = BUS;
        end
      end
      BUS: begin
        if (p_wb_ERR_I) begin
          done    = 1'b1;
          done_st = ERR;
        end else if (p_wb_RTY_I) begin
          if (retry_q < 4'(MAX_RETRY)) begin
            retry_d = retry_q + 4'd1;
            cyc_d   = 1'b0;
            lock_d  = 1'b0;
            state_d = BACKOFF;
          end else begin
            done    = 1'b1;
            done_st = RETRY_EXHAUSTED;
          end
        end else if (p_wb_ACK_I) begin
          done    = 1'b1;
          done_st = OK;
        end else if (wd_expired) begin
          done    = 1'b1;
          done_st = TIMEOUT;
        end
      end
      BACKOFF: begin
        cyc_d   = 1'b1;
        lock_d  = cmd_q.lock;
        state_d = BUS;
      end
      RSP: begin
        if (rsp_ready) begin
          vld_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      cyc_d    = 1'b0;
      lock_d   = 1'b0;
      vld_d    = 1'b1;
      status_d = done_st;
      rdat_d   = (done_st == OK && !cmd_q.we) ?
                 p_wb_DAT_I : '0;
      state_d  = RSP;
    end
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      status_q <= OK;
      retry_q  <= '0;
      rdat_q   <= '0;
      cyc_q    <= 1'b0;
      lock_q   <= 1'b0;
      rdy_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      status_q <= status_d;
      retry_q  <= retry_d;
      rdat_q   <= rdat_d;
      cyc_q    <= cyc_d;
      lock_q   <= lock_d;
      rdy_q    <= rdy_d;
      vld_q    <= vld_d;
    end
  end

  assign cmd_ready   = rdy_q;
  assign rsp_valid   = vld_q;
  assign rsp_status  = status_q;
  assign rsp_dat     = rdat_q;
  assign p_wb_ADR_O  = cmd_q.adr;
  assign p_wb_DAT_O  = cmd_q.dat;
  assign p_wb_SEL_O  = cmd_q.sel;
  assign p_wb_WE_O   = cmd_q.we;
  assign p_wb_CYC_O  = cyc_q;
  assign p_wb_STB_O  = cyc_q;
  assign p_wb_LOCK_O = lock_q;

endmodule
